// File: rtl/radix4_operand_serializer.sv
// Booth-recodes an operand pair into radix-4 signed digits and streams them MSD-first
// to the online multiplier, followed by zero-digit padding and frame markers.
module radix4_operand_serializer #(
    parameter int unsigned no_of_digits = 4,
    parameter int unsigned radix_bits   = 3,
    parameter int unsigned delta        = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*no_of_digits-1:0]   x_in,
    input  logic [2*no_of_digits-1:0]   y_in,
    input  logic                        full_in,
    output logic [radix_bits-1:0]       xout,
    output logic [radix_bits-1:0]       yout,
    output logic                        digit_valid,
    output logic                        frame_first,
    output logic                        frame_last,
    output logic                        mult_reset,
    output logic                        full_result_sel
);

    localparam int unsigned W = 2 * no_of_digits;
    // Counter preloads hold (cycles remaining - 1) so the count ends on zero.
    localparam logic [5:0] SEND_LAST = 6'(no_of_digits - 1);
    localparam logic [5:0] PAD_SHORT = 6'(delta);
    localparam logic [5:0] PAD_FULL  = 6'(no_of_digits + delta);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SEND,
        FLUSH
    } state_t;

    state_t                  state_q;
    logic [W-1:0]            x_q;
    logic [W-1:0]            y_q;
    logic [5:0]              cnt_q;
    logic                    in_ready_q;
    logic [radix_bits-1:0]   xout_q;
    logic [radix_bits-1:0]   yout_q;
    logic                    digit_valid_q;
    logic                    frame_first_q;
    logic                    frame_last_q;
    logic                    mult_reset_q;
    logic                    full_result_sel_q;

    logic [radix_bits-1:0]   xdig_d;
    logic [radix_bits-1:0]   ydig_d;
    logic [5:0]              pad_d;

    // Triplet {b[2i+1], b[2i], b[2i-1]} -> digit -2*b[2i+1] + b[2i] + b[2i-1], sign-extended.
    function automatic logic [radix_bits-1:0] booth(input logic [2:0] t);
        logic signed [2:0] d;
        case (t)
            3'b000, 3'b111: d = 3'sd0;
            3'b001, 3'b010: d = 3'sd1;
            3'b011:         d = 3'sd2;
            3'b100:         d = -3'sd2;
            default:        d = -3'sd1;
        endcase
        return radix_bits'(d);
    endfunction

    // Operands shift left two bits per digit, so the current triplet is always the top
    // three bits; the zeros shifted in supply b[-1] for the last digit.
    always_comb begin
        xdig_d = booth(x_q[W-1 -: 3]);
        ydig_d = booth(y_q[W-1 -: 3]);
        pad_d  = full_result_sel_q ? PAD_FULL : PAD_SHORT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            x_q               <= '0;
            y_q               <= '0;
            cnt_q             <= '0;
            in_ready_q        <= 1'b0;
            xout_q            <= '0;
            yout_q            <= '0;
            digit_valid_q     <= 1'b0;
            frame_first_q     <= 1'b0;
            frame_last_q      <= 1'b0;
            mult_reset_q      <= 1'b1;
            full_result_sel_q <= 1'b0;
        end else begin
            frame_first_q <= 1'b0;
            frame_last_q  <= 1'b0;
            mult_reset_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    digit_valid_q <= 1'b0;
                    xout_q        <= '0;
                    yout_q        <= '0;
                    if (in_valid && in_ready_q) begin
                        x_q               <= x_in;
                        y_q               <= y_in;
                        full_result_sel_q <= full_in;
                        in_ready_q        <= 1'b0;
                        mult_reset_q      <= 1'b1;
                        state_q           <= CLEAR;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    xout_q        <= xdig_d;
                    yout_q        <= ydig_d;
                    digit_valid_q <= 1'b1;
                    frame_first_q <= 1'b1;
                    x_q           <= x_q << 2;
                    y_q           <= y_q << 2;
                    cnt_q         <= SEND_LAST;
                    state_q       <= SEND;
                end
                SEND: begin
                    if (cnt_q != 6'd0) begin
                        xout_q <= xdig_d;
                        yout_q <= ydig_d;
                        x_q    <= x_q << 2;
                        y_q    <= y_q << 2;
                        cnt_q  <= cnt_q - 6'd1;
                    end else begin
                        xout_q       <= '0;
                        yout_q       <= '0;
                        cnt_q        <= pad_d;
                        frame_last_q <= (pad_d == 6'd0);
                        state_q      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt_q != 6'd0) begin
                        cnt_q        <= cnt_q - 6'd1;
                        frame_last_q <= (cnt_q == 6'd1);
                    end else begin
                        digit_valid_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready        = in_ready_q;
    assign xout            = xout_q;
    assign yout            = yout_q;
    assign digit_valid     = digit_valid_q;
    assign frame_first     = frame_first_q;
    assign frame_last      = frame_last_q;
    assign mult_reset      = mult_reset_q;
    assign full_result_sel = full_result_sel_q;

endmodule

// File: tb/tb_radix4_operand_serializer.sv
// Directed bench for radix4_operand_serializer: cycle-exact frames at N=4 plus an
// exhaustive recoding sweep on an N=2 instance.
module tb_radix4_operand_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic       a_reset, a_valid, a_rdy, a_full;
    logic [7:0] a_x, a_y;
    logic [2:0] a_xo, a_yo;
    logic       a_dv, a_ff, a_fl, a_mr, a_frs;

    // N=2 instance
    logic       b_reset, b_valid, b_rdy, b_full;
    logic [3:0] b_x, b_y;
    logic [2:0] b_xo, b_yo;
    logic       b_dv, b_ff, b_fl, b_mr, b_frs;

    int checks   = 0;
    int failures = 0;

    radix4_operand_serializer #(.no_of_digits(4), .radix_bits(3), .delta(2)) dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_ready(a_rdy),
        .x_in(a_x), .y_in(a_y), .full_in(a_full), .xout(a_xo), .yout(a_yo),
        .digit_valid(a_dv), .frame_first(a_ff), .frame_last(a_fl),
        .mult_reset(a_mr), .full_result_sel(a_frs)
    );

    radix4_operand_serializer #(.no_of_digits(2), .radix_bits(3), .delta(2)) dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_ready(b_rdy),
        .x_in(b_x), .y_in(b_y), .full_in(b_full), .xout(b_xo), .yout(b_yo),
        .digit_valid(b_dv), .frame_first(b_ff), .frame_last(b_fl),
        .mult_reset(b_mr), .full_result_sel(b_frs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view: {digit_valid, frame_first, frame_last, mult_reset, in_ready, full_result_sel, xout, yout}
    function automatic logic [11:0] ev(input bit dv, input bit ff, input bit fl, input bit mr,
                                       input bit rdy, input bit frs, input logic [2:0] x,
                                       input logic [2:0] y);
        return {dv, ff, fl, mr, rdy, frs, x, y};
    endfunction

    task automatic cyc(input string tag, input logic [11:0] e);
        @(negedge clk);
        chk(tag, 32'({a_dv, a_ff, a_fl, a_mr, a_rdy, a_frs, a_xo, a_yo}), 32'(e));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int to, xs, ys, xe, ye;
        logic signed [2:0] dx1, dx0, dy1, dy0;
        logic signed [3:0] xv, yv;
        logic rng_ok;

        a_reset = 1'b1; a_valid = 1'b0; a_x = '0; a_y = '0; a_full = 1'b0;
        b_reset = 1'b1; b_valid = 1'b0; b_x = '0; b_y = '0; b_full = 1'b0;

        // Reset state and release
        repeat (2) @(posedge clk);
        cyc("rst_state", ev(0,0,0,1,0,0,3'b000,3'b000));
        @(posedge clk);
        #1 a_reset = 1'b0; b_reset = 1'b0;
        cyc("rst_last", ev(0,0,0,1,0,0,3'b000,3'b000));
        cyc("rdy_after_rst", ev(0,0,0,0,1,0,3'b000,3'b000));

        // Frame 1: x=40, y=55, short product
        a_valid = 1'b1; a_x = 8'h40; a_y = 8'h55; a_full = 1'b0;
        cyc("f1_clear", ev(0,0,0,1,0,0,3'b000,3'b000));
        a_valid = 1'b0; a_x = 8'hAA; a_y = 8'h33; a_full = 1'b1;
        cyc("f1_d3", ev(1,1,0,0,0,0,3'b001,3'b001));
        cyc("f1_d2", ev(1,0,0,0,0,0,3'b000,3'b001));
        cyc("f1_d1", ev(1,0,0,0,0,0,3'b000,3'b001));
        cyc("f1_d0", ev(1,0,0,0,0,0,3'b000,3'b001));
        cyc("f1_p0", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f1_p1", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f1_last", ev(1,0,1,0,0,0,3'b000,3'b000));
        cyc("f1_idle", ev(0,0,0,0,1,0,3'b000,3'b000));

        // Frame 2: x=80 (most negative), y=FF, full product
        a_valid = 1'b1; a_x = 8'h80; a_y = 8'hFF; a_full = 1'b1;
        cyc("f2_clear", ev(0,0,0,1,0,1,3'b000,3'b000));
        a_valid = 1'b0;
        cyc("f2_d3", ev(1,1,0,0,0,1,3'b110,3'b000));
        cyc("f2_d2", ev(1,0,0,0,0,1,3'b000,3'b000));
        cyc("f2_d1", ev(1,0,0,0,0,1,3'b000,3'b000));
        cyc("f2_d0", ev(1,0,0,0,0,1,3'b000,3'b111));
        for (int i = 0; i < 6; i++) cyc("f2_pad", ev(1,0,0,0,0,1,3'b000,3'b000));
        cyc("f2_last", ev(1,0,1,0,0,1,3'b000,3'b000));
        cyc("f2_idle", ev(0,0,0,0,1,1,3'b000,3'b000));

        // Frames 3/4: in_valid held high with two queued pairs
        a_valid = 1'b1; a_x = 8'h01; a_y = 8'hFE; a_full = 1'b0;
        cyc("f3_clear", ev(0,0,0,1,0,0,3'b000,3'b000));
        a_x = 8'h7F; a_y = 8'h02;
        cyc("f3_d3", ev(1,1,0,0,0,0,3'b000,3'b000));
        cyc("f3_d2", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f3_d1", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f3_d0", ev(1,0,0,0,0,0,3'b001,3'b110));
        cyc("f3_p0", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f3_p1", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f3_last", ev(1,0,1,0,0,0,3'b000,3'b000));
        cyc("f3_gap", ev(0,0,0,0,1,0,3'b000,3'b000));
        cyc("f4_clear", ev(0,0,0,1,0,0,3'b000,3'b000));
        a_valid = 1'b0;
        cyc("f4_d3", ev(1,1,0,0,0,0,3'b010,3'b000));
        cyc("f4_d2", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f4_d1", ev(1,0,0,0,0,0,3'b000,3'b001));
        cyc("f4_d0", ev(1,0,0,0,0,0,3'b111,3'b110));
        cyc("f4_p0", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f4_p1", ev(1,0,0,0,0,0,3'b000,3'b000));
        cyc("f4_last", ev(1,0,1,0,0,0,3'b000,3'b000));
        cyc("f4_idle", ev(0,0,0,0,1,0,3'b000,3'b000));

        // Frame 5: reset during digit 2
        a_valid = 1'b1; a_x = 8'h55; a_y = 8'h40; a_full = 1'b0;
        cyc("f5_clear", ev(0,0,0,1,0,0,3'b000,3'b000));
        a_valid = 1'b0;
        cyc("f5_d3", ev(1,1,0,0,0,0,3'b001,3'b001));
        cyc("f5_d2", ev(1,0,0,0,0,0,3'b001,3'b000));
        a_reset = 1'b1;
        cyc("mid_rst", ev(0,0,0,1,0,0,3'b000,3'b000));
        a_reset = 1'b0;
        cyc("mid_rst_rdy", ev(0,0,0,0,1,0,3'b000,3'b000));
        for (int i = 0; i < 4; i++) cyc("mid_rst_quiet", ev(0,0,0,0,1,0,3'b000,3'b000));

        // Reset and in_valid in the same cycle: nothing captured
        a_reset = 1'b1; a_valid = 1'b1; a_x = 8'h7F; a_y = 8'h7F; a_full = 1'b1;
        cyc("rv_rst", ev(0,0,0,1,0,0,3'b000,3'b000));
        a_reset = 1'b0; a_valid = 1'b0;
        cyc("rv_rdy", ev(0,0,0,0,1,0,3'b000,3'b000));
        cyc("rv_nocap", ev(0,0,0,0,1,0,3'b000,3'b000));

        // Exhaustive recoding sweep on the N=2 instance
        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                to = 0;
                while (b_rdy !== 1'b1 && to < 20) begin
                    @(negedge clk);
                    to++;
                end
                chk("b_ready_wait", 32'(b_rdy), 32'd1);
                b_valid = 1'b1; b_x = xi[3:0]; b_y = yi[3:0];
                @(negedge clk);
                b_valid = 1'b0;
                to = 0;
                while (b_ff !== 1'b1 && to < 5) begin
                    @(negedge clk);
                    to++;
                end
                chk("b_first_wait", 32'(b_ff), 32'd1);
                dx1 = b_xo; dy1 = b_yo;
                @(negedge clk);
                dx0 = b_xo; dy0 = b_yo;
                xs = 4 * int'(dx1) + int'(dx0);
                ys = 4 * int'(dy1) + int'(dy0);
                xv = xi[3:0]; yv = yi[3:0];
                xe = int'(xv); ye = int'(yv);
                chk("b_sum", {xs[15:0], ys[15:0]}, {xe[15:0], ye[15:0]});
                rng_ok = (dx1 >= -3'sd2) && (dx1 <= 3'sd2) && (dx0 >= -3'sd2) && (dx0 <= 3'sd2) &&
                         (dy1 >= -3'sd2) && (dy1 <= 3'sd2) && (dy0 >= -3'sd2) && (dy0 <= 3'sd2);
                chk("b_range", 32'(rng_ok), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radix4_operand_serializer.md
# radix4_operand_serializer

Transmit-side feeder for the radix-4 online multiplier. It accepts a pair of parallel two's-complement operands through a valid/ready handshake and Booth-recodes each one into radix-4 signed digits in {-2..2}. It then streams both digit sequences MSD-first, one digit per clock, followed by zero-digit padding so the multiplier can finish its delay and, optionally, the full-precision tail. It drives the multiplier's xin/yin/extern_reset/full_result_sel inputs and frames each operation for downstream capture logic.

## Interface
- no_of_digits, 4, number of radix-4 digits per operand; operand width is 2*no_of_digits bits; legal range 2..16
- radix_bits, 3, digit width in bits; each digit is two's complement
- delta, 2, online delay of the downstream multiplier, counted in digits

- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- in_valid  in  1  operand pair offered
- in_ready  out  1  serializer can accept an operand pair
- x_in  in  2*no_of_digits  operand X, two's complement; value is x_in/4^no_of_digits
- y_in  in  2*no_of_digits  operand Y, same format as X
- full_in  in  1  captured with the operands; 1 requests the full 2N-digit product, 0 requests an N-digit product
- xout  out  radix_bits  current X digit
- yout  out  radix_bits  current Y digit
- digit_valid  out  1  xout/yout belong to an active frame
- frame_first  out  1  high with the first digit of a frame
- frame_last  out  1  high with the last padded digit of a frame
- mult_reset  out  1  one-cycle pulse driven to the multiplier's extern_reset
- full_result_sel  out  1  registered copy of full_in for the whole frame

## Operation
- State machine: IDLE, CLEAR, SEND, FLUSH.
- **IDLE**
  - in_ready=1.
  - When in_valid&&in_ready at a posedge: capture x_in, y_in and full_in, then go to CLEAR.
- **CLEAR** (one cycle)
  - mult_reset=1, digit_valid=0, then go to SEND.
  - The multiplier is therefore cleared immediately before each frame.
- **SEND** (no_of_digits cycles)
  - digit_valid=1.
  - Digit i is emitted for i = N-1 down to 0. Recoding rule: d_i = -2*b[2i+1] + b[2i] + b[2i-1], with b[-1]=0.
  - Each digit is sign-extended to radix_bits bits.
  - frame_first=1 on the i=N-1 cycle.
  - After i=0, go to FLUSH.
- **FLUSH**
  - xout=yout=0, digit_valid=1.
  - Pad length is delta+1 cycles when full_result_sel=0, and no_of_digits+delta+1 cycles when it is 1.
  - frame_last=1 on the final pad cycle, then go to IDLE.
- Recoding is exact: sum of d_i*4^i equals the signed integer value of the operand. -4^N/2 recodes to MSD -2 with all other digits 0.
- Digit and pad counting uses a single down-counter, 6 bits wide.
- Operand registers shift left by 2 bits per SEND cycle, so that the MSD triplet is always at the top.

## Timing
- Reset values:
  - state=IDLE, in_ready=0 during the reset cycle and 1 afterwards.
  - xout=yout=0, digit_valid=0, frame_first=0, frame_last=0.
  - mult_reset=1 while reset is high, so the multiplier is cleared together with the serializer.
  - full_result_sel=0.
- All outputs are registered.
- Latency: with acceptance at edge k, mult_reset is high in cycle k+1 and the first digit (frame_first) appears in cycle k+2.
- Frame length from acceptance to frame_last:
  - 1+N+delta+1 cycles when full=0.
  - 1+2N+delta+1 cycles when full=1.
- Frame period: in_ready returns high in the cycle after frame_last, so back-to-back frames have a one-cycle gap.
- in_valid while busy: the operands are not captured. The sender holds x_in/y_in until in_ready is high.
- Changes to x_in/y_in/full_in after capture have no effect on the frame in flight.
- Reset mid-frame: at the next posedge all outputs take their reset values, the frame is dropped, and no frame_last is issued.
- Reset asserted in the same cycle as in_valid: reset wins and nothing is captured.

## Test plan
- Parameters N=4, delta=2. Send x=8'h40, y=8'h55, full=0.
  - xout = 001,000,000,000; yout = 001,001,001,001.
  - Then 3 zero pad cycles.
  - frame_first on digit 1; frame_last 8 cycles after acceptance.
- Send x=8'h80, y=8'hFF, full=1.
  - xout = 110,000,000,000; yout = 000,000,000,111.
  - Then 7 zero pad cycles; full_result_sel=1 throughout the frame.
- Hold in_valid high with two queued pairs.
  - The second pair is accepted exactly one cycle after the first frame's frame_last.
  - mult_reset pulses once per frame, the cycle before frame_first.
- Assert reset during SEND digit 2.
  - The next cycle shows digit_valid=0, xout=yout=0 and mult_reset=1.
  - in_ready=1 the cycle after reset deasserts.
- Exhaustive recoding check with N=2: all 256 (x,y) pairs.
  - Sum of d_i*4^i equals the signed operand value for every pair.
  - Every digit lies in {-2..2}.
- End-to-end with the multiplier for x=8'h40, y=8'h40.
  - The z stream, accumulated MSD-first, gives product 1/16: a digit 1 in position 2 with zeros elsewhere, to N-digit precision.
